// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding, frame constants and small helpers shared by the
// PS/2 host port (ps2_host) and its receive FIFO.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX_INHIBIT,
        ST_TX_REQ,
        ST_TX_DATA,
        ST_TX_ACK,
        ST_TX_WAIT
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS  = 11;
    // host-driven falling edges: 8 data + parity + stop release
    localparam int TX_DATA_FES = 10;

    // Bit that makes data+parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    function automatic int us_to_cyc(input int clk_hz, input int us);
        return (clk_hz / 1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_host_if.sv
// ps2_host_if: bus-side and pad-side signals of the PS/2 host port.
// master = SoC/pad environment, slave = ps2_host.
interface ps2_host_if #(
    parameter int FIFO_DEPTH = 8
) ();
    logic [7:0]                  rdata;
    logic                        rstrb;
    logic [7:0]                  wdata;
    logic                        wstrb;
    logic                        busy;
    logic                        dr;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        overflow;
    logic                        frame_err;
    logic                        tx_err;
    logic                        clr_err;
    logic                        ps2_clk_i;
    logic                        ps2_dat_i;
    logic                        ps2_clk_oe;
    logic                        ps2_dat_oe;

    modport master (
        input  rdata, busy, dr, level, overflow, frame_err, tx_err,
               ps2_clk_oe, ps2_dat_oe,
        output rstrb, wdata, wstrb, clr_err, ps2_clk_i, ps2_dat_i
    );

    modport slave (
        output rdata, busy, dr, level, overflow, frame_err, tx_err,
               ps2_clk_oe, ps2_dat_oe,
        input  rstrb, wdata, wstrb, clr_err, ps2_clk_i, ps2_dat_i
    );
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: first-word-fall-through byte FIFO for received PS/2 bytes.
// A push while full is dropped and sets the sticky overflow flag, unless a
// pop happens in the same cycle, in which case both take effect.
module ps2_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        i_push,
    input  logic [7:0]                  i_wdata,
    input  logic                        i_pop,
    input  logic                        i_clr_ovf,
    output logic [7:0]                  o_rdata,
    output logic                        o_full,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_level_nxt;

    assign o_full  = (r_level == FULL_LVL);
    assign w_pop   = i_pop && (r_level != '0);
    assign w_push  = i_push && (!o_full || w_pop);
    assign w_drop  = i_push && o_full && !w_pop;

    assign o_rdata    = r_mem[r_rptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    // Occupancy change from the accepted push/pop pair.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers, level and sticky overflow (set wins over clear).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level    <= w_level_nxt;
            r_overflow <= w_drop | (r_overflow & ~i_clr_ovf);
        end
    end

endmodule

// File: rtl/ps2_host.sv
// ps2_host: PS/2 host port. Receives device frames into ps2_fifo with
// start/stop/odd-parity checking and an inter-bit timeout; optionally sends
// host-to-device bytes (inhibit, request, 10 data edges, ACK).
// Build option: define PS2_TX_EN for the transmit path; without it the port
// is receive-only and never drives the pads.
//
// state          | meaning
// ST_IDLE        | line idle, waiting for a device start bit
// ST_RX          | receiving device frame, r_bitcnt bits so far
// ST_TX_INHIBIT  | holding ps2_clk low before a transmit
// ST_TX_REQ      | data low (start), clock just released, settling
// ST_TX_DATA     | driving data/parity/stop on device falling edges
// ST_TX_ACK      | waiting for the device ACK edge
// ST_TX_WAIT     | waiting for device to release clock and data
module ps2_host
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int FIFO_DEPTH  = 8,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 3
) (
    input  logic     clk,
    input  logic     resetn,
    ps2_host_if.slave bus
);
    localparam int INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
    localparam int TMR_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int TMR_W       = $clog2(TMR_MAX + 1);
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] TIMEOUT_T = TMR_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fe;

    ps2_state_e       r_state;
    ps2_state_e       w_state_nxt;
    logic [9:0]       r_shift;
    logic [9:0]       w_shift_nxt;
    logic [10:0]      w_frame;
    logic [3:0]       r_bitcnt;
    logic [3:0]       w_bitcnt_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_frame_err;
    logic             w_frame_err_set;
    logic             w_push;
    logic             w_full_unused;
    logic [LVL_W-1:0] w_level;

`ifdef PS2_TX_EN
    localparam logic [TMR_W-1:0] INHIBIT_T = TMR_W'(INHIBIT_CYC - 1);

    logic [8:0] r_tx_shift;
    logic [8:0] w_tx_shift_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_clk_oe;
    logic       w_clk_oe_nxt;
    logic       r_dat_oe;
    logic       w_dat_oe_nxt;
    logic       r_tx_err;
    logic       w_tx_err_set;
`endif

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fe    = r_clk_prev & ~w_clk_s;
    assign w_frame = {w_dat_s, r_shift};

    // Pad input synchronisers; idle-high reset avoids a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk_i};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.ps2_dat_i};
            r_clk_prev <= w_clk_s;
        end
    end

    // Next-state, datapath and flag-event decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bitcnt_nxt    = r_bitcnt;
        w_frame_err_set = 1'b0;
        w_push          = 1'b0;
`ifdef PS2_TX_EN
        w_tx_shift_nxt  = r_tx_shift;
        w_busy_nxt      = r_busy;
        w_clk_oe_nxt    = r_clk_oe;
        w_dat_oe_nxt    = r_dat_oe;
        w_tx_err_set    = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_fe) begin
                    w_shift_nxt  = w_frame[10:1];
                    w_bitcnt_nxt = 4'd1;
                    w_state_nxt  = ST_RX;
                end
            end
            ST_RX: begin
                if (w_fe) begin
                    w_shift_nxt  = w_frame[10:1];
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'(FRAME_BITS - 1)) begin
                        w_bitcnt_nxt = 4'd0;
                        w_state_nxt  = ST_IDLE;
                        if (!w_frame[0] && w_frame[10] && (^w_frame[9:1])) begin
                            w_push = 1'b1;
                        end else begin
                            w_frame_err_set = 1'b1;
                        end
                    end
                end else if (r_timer >= TIMEOUT_T) begin
                    w_frame_err_set = 1'b1;
                    w_bitcnt_nxt    = 4'd0;
                    w_state_nxt     = ST_IDLE;
                end
            end
`ifdef PS2_TX_EN
            ST_TX_INHIBIT: begin
                if (r_timer >= INHIBIT_T) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = ST_TX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (r_timer >= TMR_W'(1)) begin
                    w_state_nxt = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (w_fe) begin
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'(TX_DATA_FES - 1)) begin
                        w_dat_oe_nxt = 1'b0;
                        w_bitcnt_nxt = 4'd0;
                        w_state_nxt  = ST_TX_ACK;
                    end else begin
                        w_dat_oe_nxt   = ~r_tx_shift[0];
                        w_tx_shift_nxt = {1'b0, r_tx_shift[8:1]};
                    end
                end
            end
            ST_TX_ACK: begin
                if (w_fe) begin
                    w_tx_err_set = w_dat_s;
                    w_state_nxt  = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (w_clk_s && w_dat_s) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef PS2_TX_EN
        // A transmit request pre-empts any partial receive without flagging it.
        if ((r_state == ST_IDLE || r_state == ST_RX) && bus.wstrb && !r_busy) begin
            w_tx_shift_nxt  = {odd_parity(bus.wdata), bus.wdata};
            w_busy_nxt      = 1'b1;
            w_clk_oe_nxt    = 1'b1;
            w_dat_oe_nxt    = 1'b0;
            w_bitcnt_nxt    = 4'd0;
            w_push          = 1'b0;
            w_frame_err_set = 1'b0;
            w_state_nxt     = ST_TX_INHIBIT;
        end

        if ((r_state == ST_TX_REQ || r_state == ST_TX_DATA ||
             r_state == ST_TX_ACK || r_state == ST_TX_WAIT) && (r_timer >= TIMEOUT_T)) begin
            w_tx_err_set = 1'b1;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = ST_IDLE;
        end
`endif

        // The fe seen during inhibit is our own clock pull-down, so it must
        // not restart the inhibit interval.
        if ((w_state_nxt != r_state) || (w_fe && (r_state != ST_TX_INHIBIT))) begin
            w_timer_nxt = '0;
        end else if (r_timer != TMR_SAT) begin
            w_timer_nxt = r_timer + 1'b1;
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    // State register and receive-side registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_timer     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_timer     <= w_timer_nxt;
            r_frame_err <= w_frame_err_set | (r_frame_err & ~bus.clr_err);
        end
    end

`ifdef PS2_TX_EN
    // Transmit-side registers and pad enables.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_shift <= '0;
            r_busy     <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_shift_nxt;
            r_busy     <= w_busy_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_tx_err   <= w_tx_err_set | (r_tx_err & ~bus.clr_err);
        end
    end

    assign bus.busy       = r_busy;
    assign bus.tx_err     = r_tx_err;
    assign bus.ps2_clk_oe = r_clk_oe;
    assign bus.ps2_dat_oe = r_dat_oe;
`else
    logic w_unused_tx;
    assign w_unused_tx    = ^{bus.wdata, bus.wstrb};
    assign bus.busy       = 1'b0;
    assign bus.tx_err     = 1'b0;
    assign bus.ps2_clk_oe = 1'b0;
    assign bus.ps2_dat_oe = 1'b0;
`endif

    ps2_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_wdata    (w_frame[8:1]),
        .i_pop      (bus.rstrb),
        .i_clr_ovf  (bus.clr_err),
        .o_rdata    (bus.rdata),
        .o_full     (w_full_unused),
        .o_level    (w_level),
        .o_overflow (bus.overflow)
    );

    assign bus.level     = w_level;
    assign bus.dr        = (w_level != '0);
    assign bus.frame_err = r_frame_err;

endmodule
